// File: rtl/router_pkg.sv
// Shared router constants: byte width, address field width and the reserved
// destination address that marks a header as undeliverable.
package router_pkg;

    localparam int ROUTER_DATA_W = 8;
    localparam int ROUTER_ADDR_W = 2;
    localparam logic [ROUTER_ADDR_W-1:0] ROUTER_ADDR_INVALID = 2'b11;

    // Source of the next byte presented on dout.
    typedef enum logic [1:0] {
        DOUT_HOLD = 2'd0,
        DOUT_HDR  = 2'd1,
        DOUT_DATA = 2'd2,
        DOUT_FULL = 2'd3
    } dout_sel_e;

    // A header is only latched when its destination names a real port.
    function automatic logic addr_is_valid(input logic [ROUTER_ADDR_W-1:0] addr);
        return addr != ROUTER_ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity of header + payload, capture of the packet's parity byte,
// and the end-of-packet compare that drives err.
// Optional feature macro: ROUTER_REG_ERR_CNT_EN adds a saturating err_cnt.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] hdr,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              err
);

    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic              err_q, err_d;
    logic              mismatch;

    assign mismatch = (int_par_q != pkt_par_q);

    // Next-state for parity accumulator, captured parity byte and error flag.
    always_comb begin
        int_par_d = int_par_q;
        if (detect_add)
            int_par_d = '0;
        else if (lfd_state)
            int_par_d = int_par_q ^ hdr;
        else if (ld_state && pkt_valid && !full_state)
            int_par_d = int_par_q ^ data_in;

        pkt_par_d = pkt_par_q;
        if (ld_state && !fifo_full && !pkt_valid)
            pkt_par_d = data_in;

        err_d = err_q;
        if (detect_add)
            err_d = 1'b0;
        else if (rst_int_reg)
            err_d = mismatch;
    end

    // Parity state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_par_q <= '0;
            pkt_par_q <= '0;
            err_q     <= 1'b0;
        end else begin
            int_par_q <= int_par_d;
            pkt_par_q <= pkt_par_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count every parity failure, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rst_int_reg && mismatch && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register; only resetn clears it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            err_cnt_q <= 8'h00;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, parks the byte that
// arrives while the FIFO is full, drives the FIFO write data, and reports
// parity_done / low_pkt_valid back to the control FSM.
// Optional feature macro: ROUTER_REG_ERR_CNT_EN adds output err_cnt[7:0].
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] full_byte_q, full_byte_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              parity_done_q, parity_done_d;
    logic              low_pkt_valid_q, low_pkt_valid_d;
    dout_sel_e         dout_sel;

    // Select the dout source; header load outranks payload, payload outranks replay.
    always_comb begin
        dout_sel = DOUT_HOLD;
        if (lfd_state)
            dout_sel = DOUT_HDR;
        else if (ld_state && !fifo_full)
            dout_sel = DOUT_DATA;
        else if (laf_state)
            dout_sel = DOUT_FULL;
    end

    // Next-state for header, parked byte, dout and the FSM handshake flags.
    always_comb begin
        hdr_d = hdr_q;
        if (detect_add && pkt_valid && addr_is_valid(data_in[ROUTER_ADDR_W-1:0]))
            hdr_d = data_in;

        full_byte_d = full_byte_q;
        if (!lfd_state && ld_state && fifo_full)
            full_byte_d = data_in;

        case (dout_sel)
            DOUT_HDR:  dout_d = hdr_q;
            DOUT_DATA: dout_d = data_in;
            DOUT_FULL: dout_d = full_byte_q;
            default:   dout_d = dout_q;
        endcase

        parity_done_d = parity_done_q;
        if (detect_add)
            parity_done_d = 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_pkt_valid_q && !parity_done_q))
            parity_done_d = 1'b1;

        low_pkt_valid_d = low_pkt_valid_q;
        if (rst_int_reg)
            low_pkt_valid_d = 1'b0;
        else if (ld_state && !pkt_valid)
            low_pkt_valid_d = 1'b1;
    end

    // Datapath and handshake registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q           <= '0;
            full_byte_q     <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            hdr_q           <= hdr_d;
            full_byte_q     <= full_byte_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .clock       (clock),
        .resetn      (resetn),
        .pkt_valid   (pkt_valid),
        .fifo_full   (fifo_full),
        .data_in     (data_in),
        .hdr         (hdr_q),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .full_state  (full_state),
        .rst_int_reg (rst_int_reg),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_cnt     (err_cnt),
`endif
        .err         (err)
    );

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: reset, good/bad parity packets, FIFO-full
// parking and replay, parity byte arriving while full, invalid address.
module tb_router_reg;

    localparam int NONE = 0, DA = 1, LFD = 2, LD = 3, LAF = 4, FULL = 5, RSTI = 6;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full;
    logic [7:0] data_in;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       parity_done, low_pkt_valid, err;
    logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    router_reg #(.DATA_W(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_cnt       (err_cnt),
`endif
        .dout          (dout)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Apply one FSM state with source inputs, then move 1 time unit past the edge.
    task automatic step(input int st, input logic pv, input logic ff, input logic [7:0] d);
        detect_add  = (st == DA);
        lfd_state   = (st == LFD);
        ld_state    = (st == LD);
        laf_state   = (st == LAF);
        full_state  = (st == FULL);
        rst_int_reg = (st == RSTI);
        pkt_valid   = pv;
        fifo_full   = ff;
        data_in     = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
        full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0; data_in = 8'h00;
        #12;
        chk8("rst_dout", dout, 8'h00);
        chk1("rst_pdone", parity_done, 1'b0);
        chk1("rst_lowpv", low_pkt_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        resetn = 1'b1;

        // Good packet: 0D, 11, 22, 33, parity 0D
        step(DA, 1, 0, 8'h0D);
        chk8("good_hdr_hold", dout, 8'h00);
        step(LFD, 1, 0, 8'h11);
        chk8("good_dout_hdr", dout, 8'h0D);
        step(LD, 1, 0, 8'h11);
        chk8("good_dout_11", dout, 8'h11);
        step(LD, 1, 0, 8'h22);
        chk8("good_dout_22", dout, 8'h22);
        step(LD, 1, 0, 8'h33);
        chk8("good_dout_33", dout, 8'h33);
        chk1("good_pdone_early", parity_done, 1'b0);
        step(LD, 0, 0, 8'h0D);
        chk8("good_dout_par", dout, 8'h0D);
        chk1("good_pdone", parity_done, 1'b1);
        chk1("good_lowpv", low_pkt_valid, 1'b1);
        step(RSTI, 0, 0, 8'h00);
        chk1("good_err", err, 1'b0);
        chk1("good_lowpv_clr", low_pkt_valid, 1'b0);
        chk1("good_pdone_keep", parity_done, 1'b1);
`ifdef ROUTER_REG_ERR_CNT_EN
        chk8("good_errcnt", err_cnt, 8'h00);
`endif

        // Bad parity: same packet, parity FF
        step(DA, 1, 0, 8'h0D);
        chk1("bad_pdone_clr", parity_done, 1'b0);
        step(LFD, 1, 0, 8'h11);
        step(LD, 1, 0, 8'h11);
        step(LD, 1, 0, 8'h22);
        step(LD, 1, 0, 8'h33);
        step(LD, 0, 0, 8'hFF);
        chk8("bad_dout_par", dout, 8'hFF);
        chk1("bad_err_before", err, 1'b0);
        step(RSTI, 0, 0, 8'h00);
        chk1("bad_err", err, 1'b1);
`ifdef ROUTER_REG_ERR_CNT_EN
        chk8("bad_errcnt", err_cnt, 8'h01);
`endif

        // Invalid address 03: hdr and dout unchanged, err cleared by detect_add
        step(DA, 1, 0, 8'h03);
        chk8("inv_dout_hold", dout, 8'hFF);
        chk1("inv_err_clr", err, 1'b0);
        step(LFD, 1, 0, 8'h00);
        chk8("inv_hdr_kept", dout, 8'h0D);

        // FIFO full mid-packet: hdr 06, payload 44 (parked), 55, parity 17
        step(DA, 1, 0, 8'h06);
        step(LFD, 1, 0, 8'h44);
        chk8("full_dout_hdr", dout, 8'h06);
        step(LD, 1, 1, 8'h44);
        chk8("full_dout_hold", dout, 8'h06);
        step(FULL, 1, 1, 8'h44);
        chk8("full_dout_hold2", dout, 8'h06);
        step(LAF, 1, 0, 8'h55);
        chk8("full_replay", dout, 8'h44);
        chk1("full_pdone_no", parity_done, 1'b0);
        step(LD, 1, 0, 8'h55);
        chk8("full_dout_55", dout, 8'h55);
        step(LD, 0, 0, 8'h17);
        chk1("full_pdone", parity_done, 1'b1);
        step(RSTI, 0, 0, 8'h00);
        chk1("full_err", err, 1'b0);

        // Parity byte arrives while full: hdr 05, payload 12, parity 17 parked.
        // The captured parity still holds 17 from the previous packet.
        step(DA, 1, 0, 8'h05);
        step(LFD, 1, 0, 8'h12);
        chk8("last_dout_hdr", dout, 8'h05);
        step(LD, 1, 0, 8'h12);
        chk8("last_dout_12", dout, 8'h12);
        step(LD, 0, 1, 8'h17);
        chk8("last_dout_hold", dout, 8'h12);
        chk1("last_lowpv", low_pkt_valid, 1'b1);
        chk1("last_pdone_no", parity_done, 1'b0);
        step(FULL, 0, 1, 8'h00);
        chk1("last_pdone_no2", parity_done, 1'b0);
        step(LAF, 0, 0, 8'h00);
        chk8("last_replay", dout, 8'h17);
        chk1("last_pdone_laf", parity_done, 1'b1);
        step(LAF, 0, 0, 8'h00);
        chk1("last_pdone_stay", parity_done, 1'b1);
        step(RSTI, 0, 0, 8'h00);
        chk1("last_err", err, 1'b0);
        chk1("last_lowpv_clr", low_pkt_valid, 1'b0);
`ifdef ROUTER_REG_ERR_CNT_EN
        chk8("last_errcnt", err_cnt, 8'h01);
`endif

        // Reset mid-packet, checked before the next clock edge
        step(DA, 1, 0, 8'h09);
        step(LFD, 1, 0, 8'h00);
        step(LD, 0, 0, 8'h09);
        chk1("mid_pre_pdone", parity_done, 1'b1);
        step(NONE, 0, 0, 8'h00);
        #2 resetn = 1'b0;
        #1;
        chk8("mid_rst_dout", dout, 8'h00);
        chk1("mid_rst_pdone", parity_done, 1'b0);
        chk1("mid_rst_lowpv", low_pkt_valid, 1'b0);
        chk1("mid_rst_err", err, 1'b0);
`ifdef ROUTER_REG_ERR_CNT_EN
        chk8("mid_rst_errcnt", err_cnt, 8'h00);
`endif
        #3 resetn = 1'b1;

        // Clean packet after reset: hdr 0A, parity 0A
        step(DA, 1, 0, 8'h0A);
        step(LFD, 1, 0, 8'h00);
        chk8("post_dout_hdr", dout, 8'h0A);
        step(LD, 0, 0, 8'h0A);
        chk1("post_pdone", parity_done, 1'b1);
        step(RSTI, 0, 0, 8'h00);
        chk1("post_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
